// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for alu_iter.
// ALU_DIV_EN adds the DIV state to the encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_DIV  = 4'hE;
    localparam logic [3:0] OP_REM  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1
`ifdef ALU_DIV_EN
        ,ST_DIV = 2'd2
`endif
    } state_t;

    // Counter must be able to hold DATA_W itself.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative engine: shift-add multiply and (with ALU_DIV_EN) restoring divide.
// hi/lo form one 2*DATA_W shift register; the final step's next value is handed to the top with done.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ALU_DIV_EN
    input  logic              is_div,
`endif
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] hi_nxt,
    output logic [DATA_W-1:0] lo_nxt
);

    localparam int CNT_W = cnt_w(DATA_W);

    logic [DATA_W-1:0] hi, lo, opnd;
    logic [CNT_W-1:0]  cnt;
    logic              run;
    logic [DATA_W:0]   mul_sum;

    assign done = run && (cnt == CNT_W'(DATA_W - 1));

    // Multiply: conditionally add multiplicand into the upper half, then shift {hi,lo} right.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

`ifdef ALU_DIV_EN
    logic            div_q;
    logic [DATA_W:0] r_sh;
    logic [DATA_W+1:0] dif;

    assign r_sh = {hi, lo[DATA_W-1]};
    assign dif  = {1'b0, r_sh} - {2'b00, opnd};

    always_comb begin
        hi_nxt = mul_sum[DATA_W:1];
        lo_nxt = {mul_sum[0], lo[DATA_W-1:1]};
        if (div_q) begin
            // Partial remainder stays below the divisor, so DATA_W bits suffice.
            if (dif[DATA_W+1]) begin
                hi_nxt = r_sh[DATA_W-1:0];
                lo_nxt = {lo[DATA_W-2:0], 1'b0};
            end else begin
                hi_nxt = dif[DATA_W-1:0];
                lo_nxt = {lo[DATA_W-2:0], 1'b1};
            end
        end
    end
`else
    always_comb begin
        hi_nxt = mul_sum[DATA_W:1];
        lo_nxt = {mul_sum[0], lo[DATA_W-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
            run  <= 1'b0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            hi   <= '0;
            lo   <= a;
            opnd <= b;
            cnt  <= '0;
            run  <= 1'b1;
`ifdef ALU_DIV_EN
            div_q <= is_div;
`endif
        end else if (run) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= done ? '0 : cnt + 1'b1;
            run <= !done;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle ops, iterative MUL and optional DIV/REM behind valid/ready.
// Build option: ALU_DIV_EN enables the divider; otherwise DIV/REM return 0 in one cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 25,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_opcode,
    input  logic [DATA_W-1:0]   a_data_in,
    input  logic [DATA_W-1:0]   b_data_in,
    input  logic                alu_src_sel,
    input  logic [IMM_W-1:0]    alu_immediate_in,
    input  logic [SHAMT_W-1:0]  shift_amt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] data_out,
    output logic                z_flag,
    output logic                carry_flag,
    output logic                busy
);

    localparam int RW = 2 * DATA_W;

    state_t            state, state_nxt;
    logic              accept, start, res_we;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W:0]   sum, diff;
    logic [RW-1:0]     sc_res, res_d;
    logic              sc_carry, sc_iter, carry_d;
    logic              md_done;
    logic [DATA_W-1:0] md_hi, md_lo;

    assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign b_val    = alu_src_sel ? DATA_W'(alu_immediate_in) : b_data_in;
    assign sum      = {1'b0, a_data_in} + {1'b0, b_val};
    assign diff     = {1'b0, a_data_in} - {1'b0, b_val};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_iter  = 1'b0;
        case (alu_opcode)
            OP_ADD:  begin sc_res = RW'(sum); sc_carry = sum[DATA_W]; end
            OP_SUB:  begin sc_res = RW'(diff[DATA_W-1:0]); sc_carry = !diff[DATA_W]; end
            OP_MUL:  sc_iter = 1'b1;
            OP_AND:  sc_res = RW'(a_data_in & b_val);
            OP_OR:   sc_res = RW'(a_data_in | b_val);
            OP_NOT:  sc_res = RW'(~a_data_in);
            OP_NOR:  sc_res = RW'(~(a_data_in | b_val));
            OP_NAND: sc_res = RW'(~(a_data_in & b_val));
            OP_XOR:  sc_res = RW'(a_data_in ^ b_val);
            OP_XNOR: sc_res = RW'(~(a_data_in ^ b_val));
            OP_INC:  sc_res = RW'({1'b0, a_data_in} + 1'b1);
            OP_DEC:  sc_res = RW'(a_data_in - 1'b1);
            OP_SHL:  sc_res = {{DATA_W{1'b0}}, a_data_in} << shift_amt;
            OP_SHR:  sc_res = RW'(a_data_in >> shift_amt);
`ifdef ALU_DIV_EN
            // Zero divisor resolves immediately: all-ones quotient, remainder = A.
            OP_DIV:  if (b_val == '0) sc_res = RW'({DATA_W{1'b1}}); else sc_iter = 1'b1;
            OP_REM:  if (b_val == '0) sc_res = RW'(a_data_in);      else sc_iter = 1'b1;
`else
            OP_DIV:  sc_res = '0;
            OP_REM:  sc_res = '0;
`endif
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [3:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      op_q <= OP_ADD;
        else if (accept) op_q <= alu_opcode;
    end
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        res_we    = 1'b0;
        res_d     = sc_res;
        carry_d   = sc_carry;
        case (state)
            ST_IDLE: if (accept) begin
                if (sc_iter) begin
                    start = 1'b1;
`ifdef ALU_DIV_EN
                    state_nxt = (alu_opcode == OP_MUL) ? ST_MUL : ST_DIV;
`else
                    state_nxt = ST_MUL;
`endif
                end else begin
                    res_we = 1'b1;
                end
            end
            ST_MUL: if (md_done) begin
                res_we    = 1'b1;
                res_d     = {md_hi, md_lo};
                carry_d   = 1'b0;
                state_nxt = ST_IDLE;
            end
`ifdef ALU_DIV_EN
            ST_DIV: if (md_done) begin
                res_we    = 1'b1;
                res_d     = RW'((op_q == OP_REM) ? md_hi : md_lo);
                carry_d   = 1'b0;
                state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    alu_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef ALU_DIV_EN
        .is_div (alu_opcode != OP_MUL),
`endif
        .a      (a_data_in),
        .b      (b_val),
        .done   (md_done),
        .hi_nxt (md_hi),
        .lo_nxt (md_lo)
    );

    // A write in the same cycle as a consume replaces the result and keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            data_out   <= '0;
            z_flag     <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (res_we) begin
                out_valid  <= 1'b1;
                data_out   <= res_d;
                z_flag     <= (res_d == '0);
                carry_flag <= carry_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (default DATA_W=32, IMM_W=25).
module tb_alu_iter;

    localparam int DATA_W  = 32;
    localparam int IMM_W   = 25;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_opcode;
    logic [DATA_W-1:0]  a_data_in;
    logic [DATA_W-1:0]  b_data_in;
    logic               alu_src_sel;
    logic [IMM_W-1:0]   alu_immediate_in;
    logic [SHAMT_W-1:0] shift_amt;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        data_out;
    logic               z_flag;
    logic               carry_flag;
    logic               busy;

    int passed = 0;
    int total  = 0;

    alu_iter #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_opcode(alu_opcode), .a_data_in(a_data_in), .b_data_in(b_data_in),
        .alu_src_sel(alu_src_sel), .alu_immediate_in(alu_immediate_in),
        .shift_amt(shift_amt), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .z_flag(z_flag), .carry_flag(carry_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one request for a single edge; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [24:0] imm, input logic [4:0] sh);
        alu_opcode = op; a_data_in = a; b_data_in = b;
        alu_src_sel = src; alu_immediate_in = imm; shift_amt = sh;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from accept (cycle 1) until out_valid; also counts busy-high samples.
    task automatic wait_result(output int lat, output int busy_cnt);
        lat = 1; busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({out_valid, data_out, z_flag, carry_flag, busy} !== 68'd0)
            $display("FAIL reset_outputs got v=%b d=%h z=%b c=%b busy=%b want all 0",
                     out_valid, data_out, z_flag, carry_flag, busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_add();
        issue(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'h1_0000_0000 || carry_flag !== 1'b1 || z_flag !== 1'b0)
            $display("FAIL add_carry got v=%b d=%h c=%b z=%b want 1 100000000 1 0",
                     out_valid, data_out, carry_flag, z_flag); else passed++;
        issue(4'h0, 32'h0, 32'h0, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'h0 || carry_flag !== 1'b0 || z_flag !== 1'b1)
            $display("FAIL add_zero got v=%b d=%h c=%b z=%b want 1 0 0 1",
                     out_valid, data_out, carry_flag, z_flag); else passed++;
    endtask

    task automatic test_sub();
        issue(4'h1, 32'd5, 32'd0, 1'b1, 25'd7, 5'd0);
        total++; if (data_out !== 64'h0000_0000_FFFF_FFFE || carry_flag !== 1'b0)
            $display("FAIL sub_borrow got d=%h c=%b want fffffffe 0", data_out, carry_flag); else passed++;
        issue(4'h1, 32'd7, 32'd0, 1'b1, 25'd5, 5'd0);
        total++; if (data_out !== 64'd2 || carry_flag !== 1'b1)
            $display("FAIL sub_noborrow got d=%h c=%b want 2 1", data_out, carry_flag); else passed++;
    endtask

    task automatic test_mul();
        int lat, bc;
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 25'h0, 5'd0);
        total++; if (in_ready !== 1'b0) $display("FAIL mul_in_ready_busy got %b want 0", in_ready); else passed++;
        wait_result(lat, bc);
        total++; if (lat !== 33) $display("FAIL mul_latency got %0d want 33", lat); else passed++;
        total++; if (bc !== 32) $display("FAIL mul_busy_cycles got %0d want 32", bc); else passed++;
        total++; if (data_out !== 64'hFFFF_FFFE_0000_0001 || carry_flag !== 1'b0 || busy !== 1'b0)
            $display("FAIL mul_result got d=%h c=%b busy=%b want fffffffe00000001 0 0",
                     data_out, carry_flag, busy); else passed++;
        // Offer a request while stalled: it must not be taken nor disturb the result.
        alu_opcode = 4'h0; a_data_in = 32'd1; b_data_in = 32'd1; alu_src_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 64'hFFFF_FFFE_0000_0001)
                $display("FAIL mul_hold%0d got v=%b rdy=%b d=%h want 1 0 fffffffe00000001",
                         i, out_valid, in_ready, data_out); else passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mul_consume got v=%b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [16];
        logic [31:0] as  [16];
        logic [31:0] bs  [16];
        logic [4:0]  shs [16];
        logic [63:0] exp [16];
        ops = '{4'h8, 4'hC, 4'h8, 4'hC, 4'h8, 4'hC, 4'h8, 4'hC,
                4'h8, 4'hC, 4'h8, 4'hC, 4'h8, 4'hC, 4'h8, 4'hC};
        as  = '{32'hFFFF0000, 32'h80000001, 32'h12345678, 32'h00000001,
                32'hAAAAAAAA, 32'hFFFFFFFF, 32'h00000000, 32'h00000003,
                32'hCAFEBABE, 32'h12345678, 32'h0000FFFF, 32'h80000000,
                32'h11111111, 32'hF0000000, 32'h00000001, 32'h00000007};
        bs  = '{32'h0F0F0F0F, 32'h0, 32'h12345678, 32'h0, 32'h55555555, 32'h0, 32'hDEADBEEF, 32'h0,
                32'hFFFFFFFF, 32'h0, 32'h00FF00FF, 32'h0, 32'h22222222, 32'h0, 32'h00000003, 32'h0};
        shs = '{5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd31,
                5'd0, 5'd8, 5'd0, 5'd1, 5'd0, 5'd16, 5'd0, 5'd30};
        exp = '{64'h00000000_F0F00F0F, 64'h40000000_80000000, 64'h0, 64'h1,
                64'h00000000_FFFFFFFF, 64'h0000000F_FFFFFFF0, 64'h00000000_DEADBEEF, 64'h00000001_80000000,
                64'h00000000_35014541, 64'h00000012_34567800, 64'h00000000_00FFFF00, 64'h00000001_00000000,
                64'h00000000_33333333, 64'h0000F000_00000000, 64'h2, 64'h00000001_C0000000};
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_src_sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            alu_opcode = ops[i]; a_data_in = as[i]; b_data_in = bs[i]; shift_amt = shs[i];
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || data_out !== exp[i] || in_ready !== 1'b1)
                $display("FAIL b2b%0d got v=%b d=%h rdy=%b want 1 %h 1",
                         i, out_valid, data_out, in_ready, exp[i]); else passed++;
        end
        in_valid = 1'b0;
        shift_amt = 5'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int lat, bc;
        out_ready = 1'b1;
`ifdef ALU_DIV_EN
        issue(4'hE, 32'd100, 32'd7, 1'b0, 25'h0, 5'd0);
        wait_result(lat, bc);
        total++; if (lat !== 33 || data_out !== 64'd14)
            $display("FAIL div_100_7 got lat=%0d d=%h want 33 e", lat, data_out); else passed++;
        @(posedge clk); #1;
        issue(4'hF, 32'd100, 32'd7, 1'b0, 25'h0, 5'd0);
        wait_result(lat, bc);
        total++; if (lat !== 33 || data_out !== 64'd2 || bc !== 32)
            $display("FAIL rem_100_7 got lat=%0d busy=%0d d=%h want 33 32 2", lat, bc, data_out); else passed++;
        @(posedge clk); #1;
        issue(4'hE, 32'd9, 32'd0, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'h0000_0000_FFFF_FFFF || busy !== 1'b0)
            $display("FAIL div_by_zero got v=%b d=%h busy=%b want 1 ffffffff 0", out_valid, data_out, busy); else passed++;
        issue(4'hF, 32'd9, 32'd0, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'd9 || z_flag !== 1'b0)
            $display("FAIL rem_by_zero got v=%b d=%h z=%b want 1 9 0", out_valid, data_out, z_flag); else passed++;
`else
        issue(4'hE, 32'd100, 32'd7, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'd0 || z_flag !== 1'b1 || carry_flag !== 1'b0 || busy !== 1'b0)
            $display("FAIL div_disabled got v=%b d=%h z=%b c=%b busy=%b want 1 0 1 0 0",
                     out_valid, data_out, z_flag, carry_flag, busy); else passed++;
        lat = 0; bc = 0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        issue(4'h0, 32'd1, 32'd1, 1'b0, 25'h0, 5'd0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'h2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 25'h0, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL mid_mul_busy got %b want 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, data_out, z_flag, carry_flag, busy} !== 68'd0)
            $display("FAIL mid_mul_reset got v=%b d=%h z=%b c=%b busy=%b want all 0",
                     out_valid, data_out, z_flag, carry_flag, busy); else passed++;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'h0, 32'd2, 32'd3, 1'b0, 25'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || data_out !== 64'd5 || carry_flag !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_reset_add got v=%b d=%h c=%b busy=%b want 1 5 0 0",
                     out_valid, data_out, carry_flag, busy); else passed++;
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        alu_opcode = 4'h0; a_data_in = '0; b_data_in = '0;
        alu_src_sel = 1'b0; alu_immediate_in = '0; shift_amt = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_div();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
